// File: rtl/board_loader_if.sv
// Serial pattern input and row-store write port of the board loader.
// master: pattern source / memory side; slave: board_loader.
interface board_loader_if #(
  parameter int COLS = 8,
  parameter int AW   = 3
);
  logic            ser_bit;
  logic            ser_valid;
  logic            ser_ready;
  logic            mem_wr_ok;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;

  modport master (
    output ser_bit, ser_valid, mem_wr_ok,
    input  ser_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  ser_bit, ser_valid, mem_wr_ok,
    output ser_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/board_loader.sv
// board_loader: shifts a serial Life pattern in and writes it row by row
// into the row store, only while the store's write slot is open.
// Ports: ph1 clock, reset (async, high), start, bus (serial in with
// ready/valid, row write port), busy, load_done pulse, par_err (sticky).
// Optional macro BOARD_LOADER_PARITY_EN: one even-parity beat per row.
module board_loader #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int AW   = 3
) (
  input  logic           ph1,
  input  logic           reset,
  input  logic           start,
  board_loader_if.slave  bus,
  output logic           busy,
  output logic           load_done,
  output logic           par_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef BOARD_LOADER_PARITY_EN
  localparam int BEATS = COLS + 1;
`else
  localparam int BEATS = COLS;
`endif
  localparam int BW = $clog2(BEATS + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);

  logic [1:0]      state;
  logic [AW-1:0]   row;
  logic [BW-1:0]   bitcnt;
  logic [COLS-1:0] shift;

  assign bus.ser_ready = (state == S_SHIFT);
  assign bus.wr_en     = (state == S_WRITE) && bus.mem_wr_ok;
  assign bus.wr_addr   = row;
  assign bus.wr_data   = shift;
  assign busy          = (state != S_IDLE);
  assign load_done     = (state == S_DONE);

`ifdef BOARD_LOADER_PARITY_EN
  logic perr_q;
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      row    <= '0;
      bitcnt <= '0;
      shift  <= '0;
`ifdef BOARD_LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SHIFT;
            row    <= '0;
            bitcnt <= '0;
          end
        end
        S_SHIFT: begin
          if (bus.ser_valid) begin
`ifdef BOARD_LOADER_PARITY_EN
            // Parity beat is checked, never shifted in.
            if (bitcnt == LAST_BEAT) begin
              bitcnt <= '0;
              if (bus.ser_bit != ^shift) begin
                perr_q <= 1'b1;
                shift  <= '0;
              end else begin
                state <= S_WRITE;
              end
            end else begin
              shift  <= {shift[COLS-2:0], bus.ser_bit};
              bitcnt <= bitcnt + BW'(1);
            end
`else
            shift <= {shift[COLS-2:0], bus.ser_bit};
            if (bitcnt == LAST_BEAT) begin
              bitcnt <= '0;
              state  <= S_WRITE;
            end else begin
              bitcnt <= bitcnt + BW'(1);
            end
`endif
          end
        end
        S_WRITE: begin
          if (bus.mem_wr_ok) begin
            if (row == LAST_ROW) begin
              state <= S_DONE;
            end else begin
              row   <= row + AW'(1);
              state <= S_SHIFT;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_loader.sv
// Bench for board_loader: table of full-board loads against a row-store
// model, plus mid-load reset and reset-state sequences.
module tb_board_loader;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int AW   = 3;
`ifdef BOARD_LOADER_PARITY_EN
  localparam int BEATS = COLS + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int BEATS = COLS;
  localparam bit PAR   = 1'b0;
`endif

  typedef logic bitq_t[$];

  typedef struct {
    logic [ROWS-1:0][COLS-1:0] rows;
    int vpct;
    int stall_row;
    int stall_len;
    bit start_busy;
    int bad_row;
    int exp_cyc;
  } vec_t;

  logic ph1 = 1'b0;
  logic reset;
  logic start;
  logic busy, load_done, par_err;
  int n_cmp = 0;
  int n_bad = 0;

  board_loader_if #(.COLS(COLS), .AW(AW)) bif ();

  board_loader #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .ph1       (ph1),
    .reset     (reset),
    .start     (start),
    .bus       (bif.slave),
    .busy      (busy),
    .load_done (load_done),
    .par_err   (par_err)
  );

  always #5 ph1 = ~ph1;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, bif.ser_ready, bif.wr_en, 5'(bif.wr_addr),
            bif.wr_data, busy, load_done, par_err};
  endfunction

  // Serial image of a board: MSB first, parity beat appended when enabled;
  // bad_row is first sent with inverted parity, then resent correctly.
  function automatic void build_q(input vec_t v, output bitq_t q);
    q = {};
    for (int r = 0; r < ROWS; r++) begin
      if (PAR && r == v.bad_row) begin
        for (int b = COLS - 1; b >= 0; b--) q.push_back(v.rows[r][b]);
        q.push_back(~^v.rows[r]);
      end
      for (int b = COLS - 1; b >= 0; b--) q.push_back(v.rows[r][b]);
      if (PAR) q.push_back(^v.rows[r]);
    end
  endfunction

  task automatic do_reset();
    @(posedge ph1); #1;
    reset = 1'b1; start = 1'b0;
    bif.ser_valid = 1'b1; bif.ser_bit = 1'b1; bif.mem_wr_ok = 1'b1;
    #1 chk("reset_outs", outs(), 32'd0);
    @(posedge ph1); #1;
    reset = 1'b0; bif.ser_valid = 1'b0;
    #1 chk("post_reset_outs", outs(), 32'd0);
  endtask

  task automatic run_load(input int id, input vec_t v);
    bitq_t q;
    logic [AW+COLS-1:0] got[$];
    int cyc, dones, done_at, stall_left;
    bit stalled, late_bad;
    build_q(v, q);
    dones = 0; done_at = -1; stall_left = v.stall_len; late_bad = 0;
    @(posedge ph1); #1;
    start = 1'b1; bif.ser_valid = 1'b0; bif.mem_wr_ok = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      bif.ser_valid = (q.size() > 0) && ($urandom_range(99) < v.vpct);
      bif.ser_bit = bif.ser_valid ? q[0] : 1'($urandom);
      stalled = (v.stall_row >= 0) && (stall_left > 0) && busy &&
                !bif.ser_ready && !load_done &&
                (int'(bif.wr_addr) == v.stall_row);
      bif.mem_wr_ok = !stalled;
      if (stalled) stall_left--;
      start = v.start_busy && bif.ser_ready &&
              (bif.wr_addr == 1 || bif.wr_addr == 6);
      @(negedge ph1);
      if (stalled)
        chk($sformatf("v%0d_stall", id),
            {bif.wr_en, bif.ser_ready, bif.wr_addr, bif.wr_data},
            {2'b00, AW'(v.stall_row), v.rows[v.stall_row]});
      if (bif.ser_valid && bif.ser_ready) void'(q.pop_front());
      if (bif.wr_en) got.push_back({bif.wr_addr, bif.wr_data});
      if (load_done) begin
        dones++;
        if (done_at < 0) done_at = cyc;
      end
      @(posedge ph1); #1;
      cyc++;
      if (done_at >= 0) break;
    end
    chk($sformatf("v%0d_timeout", id), 32'(done_at >= 0), 32'd1);
    start = 1'b0; bif.ser_valid = 1'b0; bif.mem_wr_ok = 1'b1;
    @(negedge ph1);
    chk($sformatf("v%0d_busy_after", id), {busy, load_done}, 32'd0);
    chk($sformatf("v%0d_done_count", id), dones, 1);
    chk($sformatf("v%0d_par_err", id), 32'(par_err),
        32'(PAR && v.bad_row >= 0));
    if (v.exp_cyc >= 0)
      chk($sformatf("v%0d_latency", id), done_at, v.exp_cyc);
    for (int i = 0; i < 5; i++) begin
      start = 1'b0;
      @(negedge ph1);
      if (bif.wr_en || busy || load_done) late_bad = 1;
    end
    chk($sformatf("v%0d_quiet", id), 32'(late_bad), 32'd0);
    chk($sformatf("v%0d_bits_left", id), q.size(), 0);
    chk($sformatf("v%0d_nwrites", id), got.size(), ROWS);
    for (int r = 0; r < ROWS && r < got.size(); r++)
      chk($sformatf("v%0d_row%0d", id, r), 32'(got[r]),
          32'({AW'(r), v.rows[r]}));
  endtask

  task automatic mid_reset();
    vec_t v;
    bitq_t q;
    int beats, guard;
    bit bad4;
    for (int r = 0; r < ROWS; r++) v.rows[r] = 8'($urandom) | 8'h01;
    v.bad_row = -1;
    build_q(v, q);
    beats = 0; guard = 0; bad4 = 0;
    @(posedge ph1); #1;
    start = 1'b1; bif.mem_wr_ok = 1'b1;
    @(posedge ph1); #1;
    start = 1'b0;
    while (beats < 4 * BEATS + 5 && guard < 500) begin
      bif.ser_valid = 1'b1;
      bif.ser_bit = q[0];
      @(negedge ph1);
      if (bif.ser_ready) begin
        beats++;
        void'(q.pop_front());
      end
      if (bif.wr_en && bif.wr_addr == 4) bad4 = 1;
      @(posedge ph1); #1;
      guard++;
    end
    chk("midrst_timeout", 32'(guard < 500), 32'd1);
    chk("midrst_row4_active", {bif.ser_ready, busy, 5'(bif.wr_addr)},
        {2'b11, 5'd4});
    reset = 1'b1;
    #1 chk("midrst_outs_now", outs(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ph1);
      if (bif.wr_en) bad4 = 1;
    end
    chk("midrst_no_row4_write", 32'(bad4), 32'd0);
    @(posedge ph1); #1;
    reset = 1'b0; bif.ser_valid = 1'b0;
    @(negedge ph1);
    chk("midrst_outs_after", outs(), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    int base;
    reset = 1'b1; start = 1'b0;
    bif.ser_bit = 1'b0; bif.ser_valid = 1'b0; bif.mem_wr_ok = 1'b0;
    base = ROWS * (BEATS + 1) + 1;

    for (int i = 0; i < 8; i++) begin
      tbl[i].vpct = 100; tbl[i].stall_row = -1; tbl[i].stall_len = 0;
      tbl[i].start_busy = 0; tbl[i].bad_row = -1; tbl[i].exp_cyc = base;
      for (int r = 0; r < ROWS; r++) tbl[i].rows[r] = 8'($urandom);
    end
    for (int r = 0; r < ROWS; r++) begin
      tbl[0].rows[r] = r[0] ? 8'h55 : 8'hAA;
      tbl[1].rows[r] = r[0] ? 8'h55 : 8'hAA;
      tbl[2].rows[r] = 8'h00;
    end
    tbl[1].stall_row = 2; tbl[1].stall_len = 20; tbl[1].exp_cyc = base + 20;
    tbl[2].rows[0] = 8'h40; tbl[2].rows[1] = 8'h20; tbl[2].rows[2] = 8'hE0;
    tbl[2].vpct = 50; tbl[2].exp_cyc = -1;
    tbl[3].start_busy = 1;
    tbl[4].vpct = 70; tbl[4].exp_cyc = -1;
    tbl[5].vpct = 30; tbl[5].stall_row = 5; tbl[5].stall_len = 7;
    tbl[5].exp_cyc = -1;
    tbl[6].rows[ROWS-1] = 8'hFF; tbl[6].rows[0] = 8'h80;
    tbl[7].rows[3] = 8'h07;
    if (PAR) begin
      tbl[7].bad_row = 3; tbl[7].exp_cyc = base + BEATS;
    end

    repeat (2) @(posedge ph1);
    #1 chk("init_reset_outs", outs(), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_load(i, tbl[i]);
    end
    do_reset();
    mid_reset();
    run_load(8, tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_loader.md
Name: board_loader

Overview:
- Writer side of the board row store: accepts an initial 8x8 Game-of-Life pattern as a serial bit stream and writes it row by row into the row memory that the generation engine and display scan read back.
- Writes only in cycles where the memory's write slot is open (mem_wr_ok, driven from the controller's RWSelect).
- The serial stream is backpressured while a finished row waits for its write slot.

Parameters:
- ROWS, 8, number of board rows written per load; must be <= 2**AW.
- COLS, 8, bits per row (row width).
- AW, 3, row address width.

Ports:
- ph1  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begin a full-board load; sampled only in IDLE.
- ser_bit  in  1  serial pattern bit (1 = live cell).
- ser_valid  in  1  ser_bit is valid this cycle.
- ser_ready  out  1  loader accepts a bit this cycle.
- mem_wr_ok  in  1  row memory write slot open (RWSelect = 1).
- wr_en  out  1  row write strobe.
- wr_addr  out  AW  row address being written.
- wr_data  out  COLS  row contents.
- busy  out  1  load in progress (state != IDLE).
- load_done  out  1  one-cycle pulse after the last row is written.
- par_err  out  1  sticky parity error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; row counter, bit counter, shift register and par_err all go to 0.
  - All outputs read 0 while reset is high and after it is released.
  - A load in progress is aborted with no further writes. A new start is required.
- States: IDLE, SHIFT, WRITE, DONE.
- IDLE:
  - ser_ready=0.
  - start=1 moves to SHIFT on the next edge, with row=0 and bitcnt=0.
  - start is ignored in all other states.
- SHIFT:
  - ser_ready=1.
  - A beat is a cycle with ser_valid && ser_ready. Each beat does shift <= {shift[COLS-2:0], ser_bit} and bitcnt++.
  - The first bit of a row ends up in wr_data[COLS-1].
  - The beat that makes bitcnt reach COLS moves to WRITE and clears bitcnt.
  - Cycles with ser_valid=0 hold all state.
- WRITE:
  - ser_ready=0.
  - wr_en = (state==WRITE) && mem_wr_ok, combinational.
  - wr_addr=row and wr_data=shift are held stable for the whole WRITE state.
  - Exactly one wr_en cycle per row. On that cycle: if row==ROWS-1 go to DONE; otherwise row++ and go to SHIFT.
  - If mem_wr_ok stays low, WRITE waits indefinitely and backpressures the stream.
- DONE: load_done=1 for exactly one cycle, then IDLE.
- Minimum latency: last bit of a row accepted at edge N; wr_en is possible in cycle N+1 (first cycle in WRITE). The first bit of the next row can be accepted at edge N+2.
- Rows are written in order 0..ROWS-1 with no address wrap within a load. The row counter never exceeds ROWS-1.
- A full load with mem_wr_ok held high takes 1 + ROWS*(COLS+1) + 1 cycles from start to load_done.

Optional Feature:
- Macro: BOARD_LOADER_PARITY_EN.
- Defined:
  - Each row is COLS+1 beats; the final beat is an even-parity bit over the COLS data bits.
  - On mismatch: par_err is set (sticky until reset), the row is discarded, no write occurs, the state stays SHIFT, the row counter is unchanged (the same row is re-sent), and the shift register and bitcnt are cleared.
  - On a parity match: behaviour continues to WRITE as normal.
- Not defined: rows are COLS beats, no parity check is made, and par_err is tied to 0.

Test Plan:
- Checkerboard load: reset, start, stream rows alternating 0xAA/0x55 with mem_wr_ok=1 and ser_valid=1 -> eight wr_en pulses, addr 0..7, data AA,55,AA,55,...; load_done pulses once at cycle 74 after start; busy then falls to 0.
- Write-slot stall: hold mem_wr_ok=0 for 20 cycles after row 2 completes -> ser_ready=0 and wr_addr=2 with wr_data stable throughout; exactly one wr_en in the cycle mem_wr_ok rises; streaming then resumes at row 3.
- Bursty source: toggle ser_valid at random while sending a glider (rows 0x40,0x20,0xE0,0,0,0,0,0) -> memory contents match exactly; no bit lost or duplicated.
- Mid-load reset: assert reset during row 4 bit 5 -> all outputs 0 immediately, no write to row 4; then start a new load -> writing begins at addr 0.
- start while busy: pulse start during rows 1 and 6 -> no effect; only eight writes and one load_done.
- BOARD_LOADER_PARITY_EN: send row 3 as 0x07 with parity 0 (wrong), then with parity 1 -> par_err=1, no write on the first attempt, one write of 0x07 to addr 3 on the retry.
